// File: rtl/mul4_seq.sv
// Sequential shift-and-add unsigned multiplier: one WIDTH-bit add per cycle,
// 2*WIDTH-bit product after WIDTH iterations, start/done handshake.
module mul4_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     sum;
  logic               last_step;

  // Single adder; its carry lands in acc_hi's MSB after the shift.
  always_comb begin
    if (acc_lo_q[0]) begin
      sum = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    end else begin
      sum = {1'b0, acc_hi_q};
    end
  end

  assign last_step = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (last_step) begin
          product_d = {sum[WIDTH:1], sum[0], acc_lo_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign product = product_q;

endmodule

// File: tb/tb_mul4_seq.sv
// Directed self-checking bench for mul4_seq: vector table plus hand-written
// busy-protection, back-to-back and mid-operation reset sequences.
module tb_mul4_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks;
  int errors;

  mul4_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] vp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one operation and measure done latency, busy cycles and result.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] exp);
    int n;
    int busy_cnt;
    int overlap;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    busy_cnt = busy ? 1 : 0;
    overlap = 0;
    while (!done && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
    end
    chk("done_seen", int'(done), 1);
    chk("done_latency", n, 5);
    chk("busy_cycles", busy_cnt, 4);
    chk("busy_done_overlap", overlap, 0);
    chk("product", int'(product), int'(exp));
    $display("op a=%0d b=%0d product=0x%02h expected=0x%02h latency=%0d busy=%0d",
             ta, tb_v, product, exp, n, busy_cnt);
  endtask

  initial begin
    int n;
    int dones;
    int held_bad;

    checks = 0;
    errors = 0;
    vecs[0] = '{4'd0,  4'd0,  8'h00};
    vecs[1] = '{4'd1,  4'd2,  8'h02};
    vecs[2] = '{4'd10, 4'd5,  8'h32};
    vecs[3] = '{4'd9,  4'd6,  8'h36};
    vecs[4] = '{4'd12, 4'd3,  8'h24};
    vecs[5] = '{4'd15, 4'd15, 8'hE1};
    vecs[6] = '{4'd15, 4'd1,  8'h0F};
    vecs[7] = '{4'd1,  4'd15, 8'h0F};

    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_product", int'(product), 0);
    @(negedge clk); rst = 1'b0;

    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("idle_no_activity", dones, 0);
    $display("reset/idle checked");

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vp);
    end

    // Busy protection: a second start during RUN must be ignored.
    @(negedge clk);
    a = 4'd3; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 4'd7; b = 4'd9;
    n = 0;
    while (!done && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("protect_done", int'(done), 1);
    chk("protect_product", int'(product), 8'h09);
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("protect_no_second_op", dones, 0);
    $display("busy protection: product=0x%02h expected=0x09", product);

    // Back-to-back: start held, new operands presented in the DONE cycle.
    @(negedge clk);
    a = 4'd7; b = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_first_done", int'(done), 1);
    chk("b2b_first_product", int'(product), 8'h31);
    a = 4'd2; b = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_second_accepted", int'(busy), 1);
    n = 1;
    held_bad = 0;
    while (!done && n < 12) begin
      if (product != 8'h31) held_bad++;
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_product_held", held_bad, 0);
    chk("b2b_second_spacing", n, 5);
    chk("b2b_second_product", int'(product), 8'h10);
    $display("back-to-back: 0x31 then product=0x%02h expected=0x10 spacing=%0d", product, n);

    // Reset mid-operation, asserted between clock edges.
    @(negedge clk);
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_product", int'(product), 0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("midrst_no_done", dones, 0);
    $display("mid-op reset: product=0x%02h busy=%0d done=%0d", product, busy, done);
    run_op(4'd5, 4'd5, 8'h19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
